// File: rtl/pio_arb_pkg.sv
// Shared types and constants for the PIO access arbiter.
package pio_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    localparam int unsigned PIO_DATA_ADDR = 0;
    localparam logic        AVM_CS_IDLE   = 1'b0;
    localparam logic        AVM_WRN_IDLE  = 1'b1;

    // Width of a requester index; never narrower than one bit.
    function automatic int unsigned id_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pio_rr_select.sv
// Combinational winner pick among requesters: round-robin from a pointer, or
// fixed lowest-index priority when PIO_ARB_FIXED_PRIO_EN is defined.
module pio_rr_select
    import pio_arb_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    localparam int unsigned ID_W = id_width(NREQ)
) (
`ifndef PIO_ARB_FIXED_PRIO_EN
    input  logic [ID_W-1:0] i_ptr,
`endif
    input  logic [NREQ-1:0] i_req,
    output logic            o_valid_c,
    output logic [ID_W-1:0] o_grant_c
);

`ifdef PIO_ARB_FIXED_PRIO_EN
    // Scan from the top down so the lowest set index is written last and wins.
    always_comb begin
        o_valid_c = 1'b0;
        o_grant_c = '0;
        for (int unsigned i = NREQ; i > 0; i--) begin
            if (i_req[i-1]) begin
                o_valid_c = 1'b1;
                o_grant_c = ID_W'(i - 1);
            end
        end
    end
`else
    // Scan backwards from pointer+NREQ-1 so the first set bit at/after the pointer wins.
    always_comb begin
        int unsigned w_idx;
        o_valid_c = 1'b0;
        o_grant_c = '0;
        w_idx     = 0;
        for (int unsigned k = NREQ; k > 0; k--) begin
            w_idx = (32'(i_ptr) + k - 1) % NREQ;
            if (i_req[w_idx]) begin
                o_valid_c = 1'b1;
                o_grant_c = ID_W'(w_idx);
            end
        end
    end
`endif

endmodule

// File: rtl/pio_access_arbiter.sv
// Shares one zero-wait-state Avalon-MM PIO slave between NREQ requesters.
// Build option PIO_ARB_FIXED_PRIO_EN selects fixed priority instead of round-robin.
module pio_access_arbiter
    import pio_arb_pkg::*;
#(
    parameter int unsigned NREQ   = 2,
    parameter int unsigned ADDR_W = 2,
    parameter int unsigned DATA_W = 32,
    localparam int unsigned ID_W  = id_width(NREQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ-1:0]        req_we,
    input  logic [NREQ*ADDR_W-1:0] req_addr,
    input  logic [NREQ*DATA_W-1:0] req_wdata,
    output logic [NREQ-1:0]        ack,
    output logic [DATA_W-1:0]      rdata,
    output logic                   busy,
    output logic [ID_W-1:0]        grant_id,
    output logic [ADDR_W-1:0]      avm_address,
    output logic                   avm_chipselect,
    output logic                   avm_write_n,
    output logic [DATA_W-1:0]      avm_writedata,
    input  logic [DATA_W-1:0]      avm_readdata
);

    state_e              r_state;
    logic                r_we;

    state_e              w_state_nxt;
    logic                w_we_nxt;
    logic [NREQ-1:0]     w_ack_nxt;
    logic [DATA_W-1:0]   w_rdata_nxt;
    logic [ID_W-1:0]     w_grant_nxt;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_cs_nxt;
    logic                w_wrn_nxt;
    logic [DATA_W-1:0]   w_wdata_nxt;
    logic                w_sel_valid;
    logic [ID_W-1:0]     w_sel_grant;
    int unsigned         w_sel_idx;

`ifndef PIO_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]     r_ptr;
    logic [ID_W-1:0]     w_ptr_nxt;
`endif

    pio_rr_select #(
        .NREQ      (NREQ)
    ) u_select (
`ifndef PIO_ARB_FIXED_PRIO_EN
        .i_ptr     (r_ptr),
`endif
        .i_req     (req),
        .o_valid_c (w_sel_valid),
        .o_grant_c (w_sel_grant)
    );

    assign w_sel_idx = 32'(w_sel_grant);

    // Next-state and next-output logic; the Avalon drive is computed one cycle ahead.
    always_comb begin
        w_state_nxt = r_state;
        w_we_nxt    = r_we;
        w_ack_nxt   = '0;
        w_rdata_nxt = rdata;
        w_grant_nxt = grant_id;
        w_addr_nxt  = '0;
        w_cs_nxt    = AVM_CS_IDLE;
        w_wrn_nxt   = AVM_WRN_IDLE;
        w_wdata_nxt = '0;
`ifndef PIO_ARB_FIXED_PRIO_EN
        w_ptr_nxt   = r_ptr;
`endif
        case (r_state)
            IDLE: begin
                if (w_sel_valid) begin
                    w_state_nxt = ACCESS;
                    w_grant_nxt = w_sel_grant;
                    w_we_nxt    = req_we[w_sel_idx];
                    w_cs_nxt    = 1'b1;
                    w_wrn_nxt   = ~req_we[w_sel_idx];
                    w_addr_nxt  = req_addr[w_sel_idx*ADDR_W +: ADDR_W];
                    w_wdata_nxt = req_wdata[w_sel_idx*DATA_W +: DATA_W];
                end
            end
            ACCESS: begin
                w_state_nxt         = RESP;
                w_rdata_nxt         = r_we ? '0 : avm_readdata;
                w_ack_nxt[grant_id] = 1'b1;
            end
            RESP: begin
                w_state_nxt = IDLE;
`ifndef PIO_ARB_FIXED_PRIO_EN
                w_ptr_nxt   = (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + ID_W'(1);
`endif
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_we           <= 1'b0;
            ack            <= '0;
            rdata          <= '0;
            busy           <= 1'b0;
            grant_id       <= '0;
            avm_address    <= '0;
            avm_chipselect <= AVM_CS_IDLE;
            avm_write_n    <= AVM_WRN_IDLE;
            avm_writedata  <= '0;
`ifndef PIO_ARB_FIXED_PRIO_EN
            r_ptr          <= '0;
`endif
        end else begin
            r_state        <= w_state_nxt;
            r_we           <= w_we_nxt;
            ack            <= w_ack_nxt;
            rdata          <= w_rdata_nxt;
            busy           <= (w_state_nxt != IDLE);
            grant_id       <= w_grant_nxt;
            avm_address    <= w_addr_nxt;
            avm_chipselect <= w_cs_nxt;
            avm_write_n    <= w_wrn_nxt;
            avm_writedata  <= w_wdata_nxt;
`ifndef PIO_ARB_FIXED_PRIO_EN
            r_ptr          <= w_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_pio_access_arbiter.sv
// Scoreboard bench for pio_access_arbiter with a 2-bit output PIO model.
module tb_pio_access_arbiter;

    localparam int unsigned NREQ   = 2;
    localparam int unsigned ADDR_W = 2;
    localparam int unsigned DATA_W = 32;

    typedef struct {
        int          id;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
    } acc_t;

    typedef struct {
        int          id;
        logic [31:0] rdata;
    } rsp_t;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        req_we;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_wdata;
    logic [NREQ-1:0]        ack;
    logic [DATA_W-1:0]      rdata;
    logic                   busy;
    logic [0:0]             grant_id;
    logic [ADDR_W-1:0]      avm_address;
    logic                   avm_chipselect;
    logic                   avm_write_n;
    logic [DATA_W-1:0]      avm_writedata;
    logic [DATA_W-1:0]      avm_readdata;

    logic [1:0] pio_out = 2'b00;
    int         cyc = 0;
    int         cs_cyc = -10;
    int         checks = 0;
    int         errors = 0;
    acc_t       acc_q[$];
    rsp_t       rsp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output PIO: register at address 0, other addresses read as zero.
    always @(posedge clk)
        if (avm_chipselect && !avm_write_n && avm_address == 2'd0)
            pio_out <= avm_writedata[1:0];
    assign avm_readdata = (avm_address == 2'd0) ? {30'b0, pio_out} : 32'b0;

    pio_access_arbiter #(.NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack), .rdata(rdata),
        .busy(busy), .grant_id(grant_id), .avm_address(avm_address),
        .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic expect_txn(input int id, input logic we, input logic [1:0] addr,
                              input logic [31:0] wd, input logic [31:0] rd);
        acc_q.push_back('{id: id, we: we, addr: addr, wdata: wd});
        rsp_q.push_back('{id: id, rdata: rd});
    endtask

    task automatic do_req(input int id, input logic we, input logic [1:0] addr, input logic [31:0] wd);
        bit seen;
        seen = 1'b0;
        req_we[id] = we;
        req_addr[id*ADDR_W +: ADDR_W] = addr;
        req_wdata[id*DATA_W +: DATA_W] = wd;
        req[id] = 1'b1;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            if (ack[id]) seen = 1'b1;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: requester %0d got no ack within 60 cycles", id);
        end
        @(posedge clk);
        #1;
        req[id] = 1'b0;
    endtask

    // Monitor: every chipselect cycle and every ack pulse must match the next expectation.
    task automatic monitor();
        acc_t a;
        rsp_t r;
        forever begin
            @(negedge clk);
            if (reset_n && avm_chipselect) begin
                checks++;
                if (acc_q.size() == 0) begin
                    errors++;
                    $display("FAIL access_unexpected: addr=%0d we_n=%0b wdata=0x%0h", avm_address, avm_write_n, avm_writedata);
                end else begin
                    a = acc_q.pop_front();
                    cs_cyc = cyc;
                    if (avm_write_n !== ~a.we || avm_address !== a.addr ||
                        avm_writedata !== a.wdata || 32'(grant_id) != a.id) begin
                        errors++;
                        $display("FAIL access: got id=%0d we_n=%0b addr=%0d wdata=0x%0h expected id=%0d we_n=%0b addr=%0d wdata=0x%0h",
                                 grant_id, avm_write_n, avm_address, avm_writedata, a.id, ~a.we, a.addr, a.wdata);
                    end
                end
            end
            if (reset_n && ack != '0) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    errors++;
                    $display("FAIL ack_unexpected: ack=%b rdata=0x%0h", ack, rdata);
                end else begin
                    r = rsp_q.pop_front();
                    if (ack !== NREQ'(1 << r.id) || rdata !== r.rdata || 32'(grant_id) != r.id ||
                        busy !== 1'b1 || avm_chipselect !== 1'b0 || cyc != cs_cyc + 1) begin
                        errors++;
                        $display("FAIL ack: got ack=%b rdata=0x%0h gid=%0d busy=%0b cs=%0b lat=%0d expected ack=%b rdata=0x%0h gid=%0d busy=1 cs=0 lat=1",
                                 ack, rdata, grant_id, busy, avm_chipselect, cyc - cs_cyc,
                                 NREQ'(1 << r.id), r.rdata, r.id);
                    end
                end
            end
        end
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
        fork monitor(); join_none

        // Reset then idle.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {ack, busy, 31'(grant_id), avm_chipselect, avm_write_n, avm_address},
            {2'b00, 1'b0, 31'd0, 1'b0, 1'b1, 2'b00});
        chk("reset_data", rdata | avm_writedata, 32'h0);
        @(posedge clk); #1; reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {28'd0, avm_chipselect, avm_write_n, busy, |ack}, 32'b0100);
        end

        // Single write, readback, undecoded-address read.
        @(posedge clk); #1;
        expect_txn(0, 1'b1, 2'd0, 32'h3, 32'h0);
        do_req(0, 1'b1, 2'd0, 32'h3);
        chk("pio_after_write", 32'(pio_out), 32'h3);
        expect_txn(1, 1'b0, 2'd0, 32'h0, 32'h3);
        do_req(1, 1'b0, 2'd0, 32'h0);
        expect_txn(1, 1'b0, 2'd2, 32'h0, 32'h0);
        do_req(1, 1'b0, 2'd2, 32'h0);

        // Contention: both requesters ask twice back to back.
`ifdef PIO_ARB_FIXED_PRIO_EN
        expect_txn(0, 1'b1, 2'd0, 32'h1, 32'h0);
        expect_txn(0, 1'b1, 2'd0, 32'h0, 32'h0);
        expect_txn(1, 1'b1, 2'd0, 32'h3, 32'h0);
        expect_txn(1, 1'b1, 2'd0, 32'h2, 32'h0);
`else
        expect_txn(0, 1'b1, 2'd0, 32'h1, 32'h0);
        expect_txn(1, 1'b1, 2'd0, 32'h3, 32'h0);
        expect_txn(0, 1'b1, 2'd0, 32'h0, 32'h0);
        expect_txn(1, 1'b1, 2'd0, 32'h2, 32'h0);
`endif
        fork
            begin do_req(0, 1'b1, 2'd0, 32'h1); do_req(0, 1'b1, 2'd0, 32'h0); end
            begin do_req(1, 1'b1, 2'd0, 32'h3); do_req(1, 1'b1, 2'd0, 32'h2); end
        join
        chk("pio_after_contention", 32'(pio_out), 32'h2);

        // Requester 1 pulses only during requester 0's ACCESS cycle.
        expect_txn(0, 1'b1, 2'd0, 32'h1, 32'h0);
        fork
            do_req(0, 1'b1, 2'd0, 32'h1);
            begin
                req_we[1] = 1'b1;
                req_addr[3:2] = 2'd0;
                req_wdata[63:32] = 32'h3;
                @(posedge clk); #1; req[1] = 1'b1;
                @(posedge clk); #1; req[1] = 1'b0;
            end
        join
        repeat (4) @(posedge clk);
        chk("pio_after_drop", 32'(pio_out), 32'h1);

        // Reset asserted in the middle of an ACCESS cycle.
        @(posedge clk); #1;
        req_we[0] = 1'b1; req_addr[1:0] = 2'd0; req_wdata[31:0] = 32'h3; req[0] = 1'b1;
        @(posedge clk); #2;
        chk("cs_before_reset", {30'd0, avm_chipselect, avm_write_n}, 32'b10);
        reset_n = 1'b0;
        #1;
        chk("cs_after_reset", {28'd0, avm_chipselect, avm_write_n, busy, |ack}, 32'b0100);
        req[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1; reset_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("pio_after_reset", 32'(pio_out), 32'h1);
        #1;
        expect_txn(1, 1'b0, 2'd0, 32'h0, 32'h1);
        do_req(1, 1'b0, 2'd0, 32'h0);

        // Drain the scoreboard with a bound.
        for (int n = 0; n < 50 && (acc_q.size() != 0 || rsp_q.size() != 0); n++) @(posedge clk);
        chk("scoreboard_empty", 32'(acc_q.size() + rsp_q.size()), 32'h0);
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pio_access_arbiter.md
Name: pio_access_arbiter

Overview:
Shares the single Avalon-MM slave port of the 2-bit output PIO between NREQ on-chip requesters, e.g. game-logic FSM and VGA frame-sync logic.
- Accepts a level request plus command from each requester, picks a winner (round-robin by default), and issues exactly one zero-wait-state PIO access.
- Returns a one-cycle acknowledge, with read data for reads.
- Sits between requesters and the PIO's chipselect/write_n/address/writedata/readdata pins.

Parameters:
- NREQ, 2, number of requesters (legal 2..4).
- ADDR_W, 2, PIO address width.
- DATA_W, 32, PIO data width.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NREQ  per-requester level request.
- req_we  input  NREQ  per-requester command: 1 = write, 0 = read.
- req_addr  input  NREQ*ADDR_W  per-requester address; requester i uses slice [i*ADDR_W +: ADDR_W].
- req_wdata  input  NREQ*DATA_W  per-requester write data; requester i uses slice [i*DATA_W +: DATA_W].
- ack  output  NREQ  one-cycle completion pulse to the granted requester.
- rdata  output  DATA_W  read data, valid while ack is high.
- busy  output  1  high in ACCESS and RESP.
- grant_id  output  clog2(NREQ)  index of the current or last winner.
- avm_address  output  ADDR_W  to PIO address.
- avm_chipselect  output  1  to PIO chipselect.
- avm_write_n  output  1  to PIO write_n.
- avm_writedata  output  DATA_W  to PIO writedata.
- avm_readdata  input  DATA_W  from PIO readdata; combinational from address, zero wait states.

Behaviour:
- Reset (async, any cycle, including mid-transaction):
  - state = IDLE.
  - ack = 0, rdata = 0, busy = 0, grant_id = 0.
  - avm_chipselect = 0, avm_write_n = 1, avm_address = 0, avm_writedata = 0.
  - Round-robin pointer set so requester 0 has highest priority on the first arbitration.
  - An access interrupted by reset is abandoned; no ack is issued.
- All outputs are registered. There is no combinational path from req to avm_* or ack.
- States: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE:
  - If any req bit is set at the clock edge, select a winner.
  - At that same edge, latch the winner's we, addr and wdata plus grant_id, and go to ACCESS.
  - If no req bit is set, stay in IDLE with all Avalon outputs idle.
- ACCESS (exactly 1 cycle):
  - avm_chipselect = 1, avm_write_n = ~we_latched, address and writedata from the latch.
  - At the end of the cycle, if a read, capture avm_readdata into rdata.
  - Go to RESP.
- RESP (exactly 1 cycle):
  - ack[grant_id] = 1; all other ack bits stay 0.
  - avm_chipselect = 0, avm_write_n = 1.
  - rdata holds the read value; for writes rdata holds 0.
  - Round-robin pointer moves to grant_id+1 mod NREQ.
  - Go to IDLE.
- Latency and throughput:
  - req first sampled high at edge N -> avm_chipselect high during cycle N+1 -> ack high during cycle N+2.
  - Maximum throughput is one access per 3 cycles.
- Requester handshake:
  - Hold req, we, addr and wdata stable from assertion until ack is seen.
  - Deassert req at the clock edge that samples ack = 1.
  - req still high in the IDLE cycle after ack counts as a new request.
  - Command inputs are sampled only at the arbitration edge; later changes have no effect.
  - req dropped before being granted is ignored, and no ack is issued.
- Arbitration:
  - Simultaneous requests go to the first requester at or after the pointer, with wrap-around.
  - A requester that is continuously requesting is served within NREQ transactions.
- Requests arriving during ACCESS/RESP are not sampled until the next IDLE.
- ADDR_W/DATA_W pass through unmodified. Addresses not decoded by the PIO return that slave's readdata (0).

Optional Feature:
- Macro PIO_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; the pointer register is removed and its update in RESP is a no-op.
- Undefined (default): round-robin as above.
- Handshake, latency and reset behaviour are identical in both builds.

Decomposition:
- Package pio_arb_pkg holds:
  - State enum: IDLE, ACCESS, RESP.
  - PIO_DATA_ADDR = 0.
  - AVM idle constants: chipselect 0, write_n 1.
- Sub-module pio_rr_select:
  - Combinational winner pick from req and pointer, parameterised by NREQ.
  - Holds the PIO_ARB_FIXED_PRIO_EN switch.
- FSM, command latch, Avalon drive and ack/rdata registers stay in the top level.

Test Plan:
- Reset then idle: hold reset_n = 0 for 3 cycles, release -> avm_chipselect = 0, avm_write_n = 1, ack = 0, busy = 0 for 10 cycles with req = 0.
- Single write: req[0] = 1, we = 1, addr = 0, wdata = 0x3 -> one cycle of chipselect = 1, write_n = 0, writedata = 0x3; ack[0] next cycle; PIO out_port = 2'b11.
- Readback: req[1] = 1, we = 0, addr = 0 after the above write -> ack[1] pulse with rdata = 0x00000003.
- Contention: req = 2'b11 held continuously, each requester re-asserting after its ack -> grants alternate 0,1,0,1 (round-robin build) or all go to 0 (PIO_ARB_FIXED_PRIO_EN build).
- Reset mid-access: assert reset_n = 0 during ACCESS -> chipselect drops immediately, no ack; after release, a new req[1] is served normally.
- Dropped request: req[1] pulsed for 1 cycle during another requester's ACCESS -> never granted, and ack[1] stays 0.
